rgb_led_ctrl: RTL and testbench
===============================

// Module: rgb_led_ctrl
// PURPOSE
//  Parametrised per-channel RGB LED controller for the board I/O layer. Each slide switch is
//  synchronised and debounced; every debounced rising edge advances that channel's mode
//  (OFF->STEADY->BLINK->OFF). Lit channels drive their colour through a shared PWM dimmer
//  and a shared blink timer. Outputs are registered.
// PARAMETERS
//  NUM_CH        2        number of switch/LED channels (1..8)
//  DEBOUNCE_CYC  1000000  consecutive stable cycles required to accept a switch change (>=2)
//  BLINK_HALF    25000000 cycles per blink half-period (>=2)
//  PWM_BITS      8        PWM counter width (period = 2**PWM_BITS cycles)
// PORTS
//  clk      in   1            system clock
//  rst_n    in   1            asynchronous active-low reset
//  sw       in   NUM_CH       raw switch inputs, asynchronous
//  color    in   3*NUM_CH     {r,g,b} per channel, channel i at [3i+2:3i], quasi-static
//  duty     in   PWM_BITS     global brightness; on-time = duty of 2**PWM_BITS cycles
//  led_r    out  NUM_CH       red drive, 1 = lit
//  led_g    out  NUM_CH       green drive
//  led_b    out  NUM_CH       blue drive
//  mode     out  2*NUM_CH     channel mode: 0=OFF 1=STEADY 2=BLINK (3 never driven)
// BEHAVIOUR
//  Reset (async assert, sync release): led_r/g/b=0, mode=0 (OFF), sync FFs, debounced state,
//   debounce/PWM/blink counters all 0, blink_phase=0.
//  Sync: 2-FF synchroniser per sw bit.
//  Debounce: per channel; counter increments while sync!=stable, clears when equal; when it
//   reaches DEBOUNCE_CYC-1 and still differs, stable<=sync and counter clears. Glitch shorter
//   than DEBOUNCE_CYC cycles -> no change. Counter saturates, never wraps.
//  Press: one-cycle pulse on stable 0->1; falling edge ignored. sw held high through reset
//   exit counts as a press (stable starts 0).
//  Latency: sw edge -> mode change = 2 (sync) + DEBOUNCE_CYC + 1 cycles.
//  Mode FSM per channel, on press: OFF->STEADY, STEADY->BLINK, BLINK->OFF; else hold.
//  PWM: free-running PWM_BITS counter, wraps; pwm_on = (pwm_cnt < duty). duty=0 -> always dark;
//   duty=2**PWM_BITS-1 -> dark 1 cycle per period. duty change takes effect next cycle.
//  Blink: free-running counter 0..BLINK_HALF-1; at wrap blink_phase toggles. Shared, not
//   restarted on mode entry.
//  Output (registered, 1 cycle after inputs): lit = pwm_on & (mode==STEADY |
//   (mode==BLINK & blink_phase)); led_x[i] = color[i].x & lit[i].
//  Simultaneous press on several channels: each advances independently in the same cycle.
//  Reset mid-operation: everything returns to reset values immediately; no press is generated
//   by the reset itself.
// CONFIGURATION
//  RGB_LED_BLINK_EN defined: 3-state FSM as above, blink counter present.
//  Not defined: FSM is OFF<->STEADY only (STEADY->OFF on press); mode never 2; blink counter
//   and blink_phase removed; lit = pwm_on & (mode==STEADY).
// TESTING (NUM_CH=2, DEBOUNCE_CYC=4, BLINK_HALF=8, PWM_BITS=2, duty=3, macro defined)
//  1 Reset: rst_n=0 mid-run with ch0 in BLINK -> all led=0, mode=0 same cycle, stays 0 after release.
//  2 ch0 color=3'b011, sw[0] 0->1 held -> mode[1:0]=1 exactly 7 cycles later; led_g[0]/led_b[0]
//    high 3 of every 4 cycles, led_r[0]=0.
//  3 sw[0] pulse high 3 cycles then low -> mode unchanged, no LED activity.
//  4 Three presses on ch1 (color 3'b100) -> mode 1,2,0; in mode 2 led_r[1] pattern gated 8 on/8 off.
//  5 Both sw rise same cycle -> both modes 0->1 same cycle; duty=0 -> all leds 0 though mode=1.
//  6 Macro undefined: two presses on ch0 -> mode 1 then 0, never 2.

Source files
------------

// File: rtl/rgb_led_ctrl_if.sv
// rgb_led_ctrl_if: board-side bundle for the RGB LED controller.
//   sw     raw switch inputs (asynchronous)
//   color  {r,g,b} per channel, channel i at [3i+2:3i]
//   duty   global PWM brightness
//   led_r/led_g/led_b  registered LED drives, 1 = lit
//   mode   per-channel mode, 2 bits each (0=OFF 1=STEADY 2=BLINK)
// master = board/stimulus side, slave = controller.
interface rgb_led_ctrl_if #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned PWM_BITS = 8
);
    logic [NUM_CH-1:0]   sw;
    logic [3*NUM_CH-1:0] color;
    logic [PWM_BITS-1:0] duty;
    logic [NUM_CH-1:0]   led_r;
    logic [NUM_CH-1:0]   led_g;
    logic [NUM_CH-1:0]   led_b;
    logic [2*NUM_CH-1:0] mode;

    modport master (
        output sw, color, duty,
        input  led_r, led_g, led_b, mode
    );

    modport slave (
        input  sw, color, duty,
        output led_r, led_g, led_b, mode
    );
endinterface

// File: rtl/rgb_led_ctrl.sv
// rgb_led_ctrl: per-channel RGB LED controller. Each switch is synchronised
// and debounced; every debounced rising edge advances the channel mode
// (OFF->STEADY->BLINK->OFF). Lit channels share one PWM dimmer and one blink
// timer. All outputs are registered.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    rgb_led_ctrl_if.slave (sw, color, duty in; led_r/g/b, mode out)
// Configuration macro RGB_LED_BLINK_EN:
//   defined     3-state mode FSM with shared blink timer (BLINK_HALF parameter)
//   undefined   OFF<->STEADY only, no blink timer
module rgb_led_ctrl #(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned PWM_BITS     = 8
`ifdef RGB_LED_BLINK_EN
    ,
    parameter int unsigned BLINK_HALF   = 25000000
`endif
) (
    input logic            clk,
    input logic            rst_n,
    rgb_led_ctrl_if.slave  bus
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_STEADY = 2'd1,
        MODE_BLINK  = 2'd2
    } mode_e;

    logic [NUM_CH-1:0]   sync1;
    logic [NUM_CH-1:0]   sync2;
    logic [NUM_CH-1:0]   stable;
    logic [NUM_CH-1:0]   stable_d;
    logic [NUM_CH-1:0]   press_c;
    logic [DB_W-1:0]     db_cnt [NUM_CH];
    mode_e               state     [NUM_CH];
    mode_e               state_nxt [NUM_CH];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on_c;
    logic [NUM_CH-1:0]   lit_c;

    // Two-flop synchroniser, debounce counter and press-edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= bus.sw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Press = debounced rising edge; reset clears both history flops so
    // leaving reset never fabricates a press.
    assign press_c = stable & ~stable_d;

    // Mode state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= MODE_OFF;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= state_nxt[i];
            end
        end
    end

    // Mode next-state: each channel advances independently on its press
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt[i] = state[i];
            if (press_c[i]) begin
                case (state[i])
                    MODE_OFF:    state_nxt[i] = MODE_STEADY;
`ifdef RGB_LED_BLINK_EN
                    MODE_STEADY: state_nxt[i] = MODE_BLINK;
`else
                    MODE_STEADY: state_nxt[i] = MODE_OFF;
`endif
                    default:     state_nxt[i] = MODE_OFF;
                endcase
            end
        end
    end

    // Free-running PWM counter shared by all channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    assign pwm_on_c = (pwm_cnt < bus.duty);

`ifdef RGB_LED_BLINK_EN
    localparam int unsigned BL_W = $clog2(BLINK_HALF);

    logic [BL_W-1:0] blink_cnt;
    logic            blink_phase;

    // Shared blink timer; never restarted by mode changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BL_W'(BLINK_HALF - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BL_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            lit_c[i] = pwm_on_c & ((state[i] == MODE_STEADY) |
                                   ((state[i] == MODE_BLINK) & blink_phase));
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            lit_c[i] = pwm_on_c & (state[i] == MODE_STEADY);
        end
    end
`endif

    // Registered colour drives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.led_r <= '0;
            bus.led_g <= '0;
            bus.led_b <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                bus.led_r[i] <= bus.color[3*i+2] & lit_c[i];
                bus.led_g[i] <= bus.color[3*i+1] & lit_c[i];
                bus.led_b[i] <= bus.color[3*i]   & lit_c[i];
            end
        end
    end

    // Mode output is the state register itself
    always_comb begin
        bus.mode = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.mode[2*i +: 2] = state[i];
        end
    end

endmodule

// File: tb/tb_rgb_led_ctrl.sv
// tb_rgb_led_ctrl: directed bench for rgb_led_ctrl (2 channels, debounce 4,
// blink half-period 8, 2-bit PWM). Stimulus pushes expected mode events and
// expected LED on-counts over 32-cycle windows; a monitor compares them.
module tb_rgb_led_ctrl;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DEB    = 4;
    localparam int unsigned BH     = 8;
    localparam int unsigned PB     = 2;
    localparam int unsigned WIN    = 32;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    int unsigned cyc   = 0;

    rgb_led_ctrl_if #(.NUM_CH(NUM_CH), .PWM_BITS(PB)) bus ();

    rgb_led_ctrl #(
        .NUM_CH       (NUM_CH),
        .DEBOUNCE_CYC (DEB),
        .PWM_BITS     (PB)
`ifdef RGB_LED_BLINK_EN
        ,
        .BLINK_HALF   (BH)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int unsigned cyc;
        int unsigned ch;
        logic [1:0]  mode;
    } mode_ev_t;

    typedef struct packed {
        int unsigned     start;
        int unsigned     len;
        logic [5:0][7:0] exp;   // index 3*ch + {0:r,1:g,2:b}
    } win_t;

    mode_ev_t mode_q[$];
    win_t     win_q[$];
    int       n_checks = 0;
    int       n_fail   = 0;
    int       exp_mode [NUM_CH];
    int       acc [6];
    logic [2*NUM_CH-1:0] prev_mode = '0;

    // Monitor: mode changes pop the event queue; LED windows accumulate counts
    always @(negedge clk) begin : mon
        mode_ev_t ev;
        win_t     w;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.mode[2*i +: 2] != prev_mode[2*i +: 2]) begin
                n_checks++;
                if (mode_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mode_unexpected ch%0d: got mode %0d at cycle %0d, expected no change",
                             i, bus.mode[2*i +: 2], cyc);
                end else begin
                    ev = mode_q.pop_front();
                    if (ev.ch != i || ev.mode != bus.mode[2*i +: 2] || ev.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL mode_event: got ch%0d mode %0d at cycle %0d, expected ch%0d mode %0d at cycle %0d",
                                 i, bus.mode[2*i +: 2], cyc, ev.ch, ev.mode, ev.cyc);
                    end
                end
            end
        end
        prev_mode = bus.mode;

        if (win_q.size() > 0 && cyc >= win_q[0].start) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[3*i]   += int'(bus.led_r[i]);
                acc[3*i+1] += int'(bus.led_g[i]);
                acc[3*i+2] += int'(bus.led_b[i]);
            end
            if (cyc == win_q[0].start + win_q[0].len - 1) begin
                w = win_q.pop_front();
                for (int k = 0; k < 6; k++) begin
                    n_checks++;
                    if (acc[k] != int'(w.exp[k])) begin
                        n_fail++;
                        $display("FAIL led_window ch%0d col%0d (start %0d): got %0d lit cycles, expected %0d",
                                 k / 3, k % 3, w.start, acc[k], w.exp[k]);
                    end
                    acc[k] = 0;
                end
            end
        end
    end

    // Reset assertion must clear every output immediately
    always @(negedge rst_n) begin
        #1;
        n_checks++;
        if (bus.mode !== '0 || bus.led_r !== '0 || bus.led_g !== '0 || bus.led_b !== '0) begin
            n_fail++;
            $display("FAIL reset_clear: got mode=%h r=%b g=%b b=%b, expected all zero",
                     bus.mode, bus.led_r, bus.led_g, bus.led_b);
        end
    end

    function automatic int next_mode(input int m);
`ifdef RGB_LED_BLINK_EN
        return (m == 2) ? 0 : m + 1;
`else
        return (m == 1) ? 0 : 1;
`endif
    endfunction

    // Lit cycles in any 32-cycle window: steady = 8 periods x duty,
    // blink = half of that (window spans exactly two 8-cycle on-phases).
    function automatic int lit_per_win(input int m, input int d);
        if (m == 1) return 8 * d;
        if (m == 2) return 4 * d;
        return 0;
    endfunction

    task automatic push_window();
        win_t w;
        logic [2:0] col;
        int lit;
        w.start = cyc + 1;
        w.len   = WIN;
        for (int i = 0; i < NUM_CH; i++) begin
            col = bus.color[3*i +: 3];
            lit = lit_per_win(exp_mode[i], int'(bus.duty));
            w.exp[3*i]   = col[2] ? 8'(lit) : 8'd0;
            w.exp[3*i+1] = col[1] ? 8'(lit) : 8'd0;
            w.exp[3*i+2] = col[0] ? 8'(lit) : 8'd0;
        end
        win_q.push_back(w);
        repeat (WIN + 2) @(negedge clk);
    endtask

    // Hold switches high long enough to debounce, then release
    task automatic press(input logic [NUM_CH-1:0] mask);
        mode_ev_t ev;
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i]) begin
                bus.sw[i]   = 1'b1;
                exp_mode[i] = next_mode(exp_mode[i]);
                ev.cyc  = cyc + 7;
                ev.ch   = i;
                ev.mode = 2'(exp_mode[i]);
                mode_q.push_back(ev);
            end
        end
        repeat (10) @(negedge clk);
        bus.sw = bus.sw & ~mask;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse(input int ch, input int n);
        @(negedge clk);
        bus.sw[ch] = 1'b1;
        repeat (n) @(negedge clk);
        bus.sw[ch] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic reset_mid();
        mode_ev_t ev;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (exp_mode[i] != 0) begin
                ev.cyc  = cyc;
                ev.ch   = i;
                ev.mode = 2'd0;
                mode_q.push_back(ev);
            end
            exp_mode[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) exp_mode[i] = 0;
        for (int k = 0; k < 6; k++) acc[k] = 0;
        bus.sw    = '0;
        bus.color = {3'b100, 3'b011};
        bus.duty  = 2'd3;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        push_window();              // idle after reset: all dark
        press(2'b01);               // ch0 OFF->STEADY after 7 cycles
        push_window();              // g/b 24 of 32, r 0
        pulse(0, 3);                // short glitch: no mode change
        push_window();
        for (int p = 0; p < 3; p++) begin
            press(2'b10);           // ch1 through its mode cycle
            push_window();
        end
        press(2'b01);               // ch0 to BLINK (or back to OFF)
        push_window();
        reset_mid();                // async clear, no press on release
        push_window();
        press(2'b11);               // simultaneous presses
        push_window();
        @(negedge clk);
        bus.duty = 2'd0;            // duty 0: dark despite STEADY
        repeat (2) @(negedge clk);
        push_window();
        bus.duty = 2'd1;
        repeat (2) @(negedge clk);
        push_window();
        repeat (5) @(negedge clk);

        n_checks++;
        if (mode_q.size() != 0 || win_q.size() != 0) begin
            n_fail++;
            $display("FAIL queues_drained: got %0d mode events and %0d windows pending, expected 0",
                     mode_q.size(), win_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
